// File: rtl/grapheme_pxl_gw_param.sv
// ---------------------------------------------------------------------------
// grapheme_pxl_gw_param
//   Pixel gateway: turns READ_PXL / WRITE_PXL jobs addressed by (x, y) into
//   single-word memory requests at address y*H_RES + x, and returns read
//   pixels as tagged responses {dst=job_src, src=NODE_ID, id=job_id, pxl}.
//
//   Optional feature macro: GRAPHEME_PXL_GW_BOUNDS_CHK_EN
//     defined   : jobs with x >= H_RES or y >= V_RES are swallowed (accepted,
//                 no memory access, no response, no credit) and set oob_err.
//     undefined : no range check, oob_err is tied low.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   job_*                    valid/ready job channel (rd=1 read, rd=0 write)
//   mem_*                    one outstanding request, held while mem_wait=1;
//                            read data comes back in order on mem_rd_valid
//   rsp_*                    valid/ready response channel for reads
//   clear_flags              clears the sticky oob_err / rd_ovrflw flags
//   oob_err, rd_ovrflw       sticky error flags
//   rd_used                  read credits in use (accepted, not yet responded)
// ---------------------------------------------------------------------------

// Small first-word-fall-through FIFO. Storage is not reset; only the
// pointers and occupancy are, which is enough to make it empty.
module grapheme_pxl_gw_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end
endmodule

module grapheme_pxl_gw_param #(
  parameter int H_RES      = 1280,
  parameter int V_RES      = 720,
  parameter int MEM_ADDR_W = 20,
  parameter int MEM_DATA_W = 32,
  parameter int PXL_W      = 24,
  parameter int NODE_ID    = 0,
  parameter int RD_DEPTH   = 8,
  parameter int ID_W       = 8,
  localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1,
  localparam int CNT_W = $clog2(RD_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // job channel
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic                  job_rd,
  input  logic [ID_W-1:0]       job_src,
  input  logic [ID_W-1:0]       job_id,
  input  logic [X_W-1:0]        job_x,
  input  logic [Y_W-1:0]        job_y,
  input  logic [PXL_W-1:0]      job_pxl,
  // memory
  input  logic                  mem_wait,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_rd_valid,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_dst,
  output logic [ID_W-1:0]       rsp_src,
  output logic [ID_W-1:0]       rsp_id,
  output logic [PXL_W-1:0]      rsp_pxl,
  // status
  input  logic                  clear_flags,
  output logic                  oob_err,
  output logic                  rd_ovrflw,
  output logic [CNT_W-1:0]      rd_used
);
  // Wide enough for y*H_RES + x even when H_RES is a power of two.
  localparam int FULL_W = X_W + Y_W + 2;

  logic              req_pend;
  logic              accept;
  logic              oob;
  logic              issue;
  logic [FULL_W-1:0] addr_full;

  logic              hdr_push, hdr_empty, hdr_full;
  logic [2*ID_W-1:0] hdr_rdata;
  logic [CNT_W-1:0]  hdr_cnt;

  logic              dat_push, dat_empty, dat_full;
  logic [PXL_W-1:0]  dat_rdata;
  logic [CNT_W-1:0]  dat_cnt;

  logic              rsp_pop;
  logic              ovrflw_set;
  logic              unused_ok;

  // ------------------------------------------------------------------ job in
  // A pending request may be replaced in the same cycle it completes, so the
  // memory port can take one request per cycle when mem_wait stays low.
  // Every header in the FIFO holds one credit, so the header count is
  // exactly the number of credits in use.
  assign req_pend  = mem_wren | mem_rden;
  assign rd_used   = hdr_cnt;
  assign job_ready = ~rst & (~req_pend | ~mem_wait) & (rd_used < CNT_W'(RD_DEPTH));
  assign accept    = job_valid & job_ready;

  assign addr_full = FULL_W'(job_y) * FULL_W'(H_RES) + FULL_W'(job_x);

`ifdef GRAPHEME_PXL_GW_BOUNDS_CHK_EN
  assign oob = (32'(job_x) >= 32'(H_RES)) | (32'(job_y) >= 32'(V_RES));
`else
  assign oob = 1'b0;
`endif

  assign issue = accept & ~oob;

  // ------------------------------------------------------------ memory port
  // Address/data are only reloaded on a new issue, so they hold through any
  // stall; the strobes drop once the request completes with mem_wait low.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_wren  <= ~job_rd;
      mem_rden  <= job_rd;
      mem_addr  <= MEM_ADDR_W'(addr_full);
      mem_wdata <= MEM_DATA_W'(job_pxl);
    end else if (~mem_wait) begin
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
    end
  end

  // ------------------------------------------------------- read bookkeeping
  // The header is pushed at accept time, ahead of the data, so returned data
  // is accepted only while some header still lacks its data word.
  assign hdr_push   = issue & job_rd;
  assign dat_push   = mem_rd_valid & ~dat_full & (dat_cnt < hdr_cnt);
  assign ovrflw_set = mem_rd_valid & ~dat_push;

  assign rsp_valid  = ~hdr_empty & ~dat_empty;
  assign rsp_pop    = rsp_valid & rsp_ready;

  grapheme_pxl_gw_fifo #(.DEPTH(RD_DEPTH), .W(2*ID_W)) u_hdr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hdr_push),
    .wdata ({job_src, job_id}),
    .pop   (rsp_pop),
    .rdata (hdr_rdata),
    .empty (hdr_empty),
    .full  (hdr_full),
    .count (hdr_cnt)
  );

  grapheme_pxl_gw_fifo #(.DEPTH(RD_DEPTH), .W(PXL_W)) u_dat_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dat_push),
    .wdata (mem_rdata[PXL_W-1:0]),
    .pop   (rsp_pop),
    .rdata (dat_rdata),
    .empty (dat_empty),
    .full  (dat_full),
    .count (dat_cnt)
  );

  assign rsp_dst = hdr_rdata[2*ID_W-1:ID_W];
  assign rsp_id  = hdr_rdata[ID_W-1:0];
  assign rsp_src = ID_W'(NODE_ID);
  assign rsp_pxl = dat_rdata;

  // Upper memory data bits carry no pixel information; header FIFO can never
  // be full on a push because credits are checked first.
  assign unused_ok = ^{mem_rdata, hdr_full};

  // ----------------------------------------------------------- sticky flags
  // A set in the same cycle as clear_flags wins.
  always_ff @(posedge clk) begin
    if (rst)              rd_ovrflw <= 1'b0;
    else if (ovrflw_set)  rd_ovrflw <= 1'b1;
    else if (clear_flags) rd_ovrflw <= 1'b0;
  end

`ifdef GRAPHEME_PXL_GW_BOUNDS_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)                   oob_err <= 1'b0;
    else if (accept & oob)     oob_err <= 1'b1;
    else if (clear_flags)      oob_err <= 1'b0;
  end
`else
  assign oob_err = 1'b0;
`endif

endmodule

// File: tb/tb_grapheme_pxl_gw_param.sv
`timescale 1ns/1ps
module tb_grapheme_pxl_gw_param;
  localparam int H_RES = 1280;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0, job_ready, job_rd = 1'b0;
  logic [7:0]  job_src = '0, job_id = '0;
  logic [10:0] job_x = '0;
  logic [9:0]  job_y = '0;
  logic [23:0] job_pxl = '0;
  logic        mem_wait = 1'b0, mem_wren, mem_rden;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [7:0]  rsp_dst, rsp_src, rsp_id;
  logic [23:0] rsp_pxl;
  logic        clear_flags = 1'b0, oob_err, rd_ovrflw;
  logic [3:0]  rd_used;

  always #5 clk = ~clk;

  grapheme_pxl_gw_param dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_rd(job_rd),
    .job_src(job_src), .job_id(job_id), .job_x(job_x), .job_y(job_y), .job_pxl(job_pxl),
    .mem_wait(mem_wait), .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dst(rsp_dst), .rsp_src(rsp_src),
    .rsp_id(rsp_id), .rsp_pxl(rsp_pxl),
    .clear_flags(clear_flags), .oob_err(oob_err), .rd_ovrflw(rd_ovrflw), .rd_used(rd_used)
  );

  typedef struct packed {
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [7:0]  id;
    logic [23:0] pxl;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        obs_q[$];
  logic [31:0] ret_q[$];
  int          n_cmp = 0, n_fail = 0;
  int          n_rd_done = 0, n_wr_done = 0;
  bit          ret_en = 1'b1;

  // Memory contents: every word's low 24 bits are a fixed function of its address.
  function automatic logic [23:0] pxl_of(input int unsigned a);
    return 24'(a * 3 + 7);
  endfunction

  // Memory + response monitor, acting 1ns before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (ret_en && ret_q.size() > 0) begin
        mem_rd_valid = 1'b1;
        mem_rdata    = ret_q.pop_front();
      end else begin
        mem_rd_valid = 1'b0;
      end
      if (!rst && mem_rden && !mem_wait) begin
        ret_q.push_back({8'hC3, pxl_of(int'(mem_addr))});
        n_rd_done++;
      end
      if (!rst && mem_wren && !mem_wait) n_wr_done++;
      if (!rst && rsp_valid && rsp_ready) obs_q.push_back({rsp_dst, rsp_src, rsp_id, rsp_pxl});
    end
  end

  // Offers one job; returns 1ns after the accepting edge.
  task automatic drive_job(input logic rd, input logic [7:0] src, input logic [7:0] id,
                           input logic [10:0] x, input logic [9:0] y, input logic [23:0] pxl);
    int c;
    @(negedge clk);
    job_rd = rd; job_src = src; job_id = id; job_x = x; job_y = y; job_pxl = pxl;
    job_valid = 1'b1;
    #1;
    c = 0;
    while (!job_ready && c < 64) begin
      @(negedge clk); #1; c++;
    end
    if (!job_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL job_accept_timeout: job_ready=%0b required 1", job_ready);
      job_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL reset_job_ready: got %0b want 0", job_ready); end
    n_cmp++;
    if ({mem_wren, mem_rden, mem_addr, mem_wdata, rsp_valid, oob_err, rd_ovrflw, rd_used} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: wren=%0b rden=%0b addr=%0h wdata=%0h rsp_valid=%0b oob=%0b ovf=%0b used=%0d want all 0",
               mem_wren, mem_rden, mem_addr, mem_wdata, rsp_valid, oob_err, rd_ovrflw, rd_used);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b want 1", job_ready); end
  endtask

  task automatic test_write();
    int wr0 = n_wr_done;
    drive_job(1'b0, 8'd3, 8'd9, 11'd5, 10'd2, 24'hABCDEF);
    n_cmp++; if (mem_wren !== 1'b1 || mem_rden !== 1'b0) begin n_fail++; $display("FAIL write_strobe: wren=%0b rden=%0b want 1/0", mem_wren, mem_rden); end
    n_cmp++; if (mem_addr !== 20'd2565) begin n_fail++; $display("FAIL write_addr: got %0d want 2565", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h00ABCDEF) begin n_fail++; $display("FAIL write_data: got %h want 00abcdef", mem_wdata); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || obs_q.size() != 0 || rd_used !== 4'd0) begin
      n_fail++; $display("FAIL write_no_rsp: rsp_valid=%0b obs=%0d used=%0d want 0/0/0", rsp_valid, obs_q.size(), rd_used);
    end
    n_cmp++; if (n_wr_done - wr0 != 1) begin n_fail++; $display("FAIL write_count: got %0d want 1", n_wr_done - wr0); end
  endtask

  task automatic test_read_wait();
    int   rd0 = n_rd_done;
    rsp_t o, e;
    exp_q.push_back({8'd7, 8'd0, 8'd42, pxl_of(1280)});
    mem_wait = 1'b1;
    drive_job(1'b1, 8'd7, 8'd42, 11'd0, 10'd1, 24'h0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_rden !== 1'b1 || mem_addr !== 20'd1280) begin
        n_fail++; $display("FAIL wait_hold[%0d]: rden=%0b addr=%0d want 1/1280", i, mem_rden, mem_addr);
      end
      if (i < 3) begin
        n_cmp++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready[%0d]: got %0b want 0", i, job_ready); end
      end else begin
        mem_wait = 1'b0;
        #1;
        n_cmp++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL wait_release_ready: got %0b want 1", job_ready); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (mem_rden !== 1'b0) begin n_fail++; $display("FAIL wait_done_rden: got %0b want 0", mem_rden); end
    for (int c = 0; c < 100 && obs_q.size() < 1; c++) @(posedge clk);
    #1;
    n_cmp++; if (n_rd_done - rd0 != 1) begin n_fail++; $display("FAIL wait_single_req: got %0d want 1", n_rd_done - rd0); end
    n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL wait_rsp_count: got %0d want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL wait_rsp: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_fill();
    rsp_t o, e;
    int   got;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({8'd5, 8'd0, 8'(i), pxl_of((i + 3) * H_RES + i * 7)});
      drive_job(1'b1, 8'd5, 8'(i), 11'(i * 7), 10'(i + 3), 24'h0);
    end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (rd_used !== 4'd8) begin n_fail++; $display("FAIL fill_used: got %0d want 8", rd_used); end
    n_cmp++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %0b want 0", job_ready); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 8'd0 || rsp_pxl !== exp_q[0].pxl) begin
        n_fail++; $display("FAIL fill_hold[%0d]: valid=%0b id=%0d pxl=%h want 1/0/%h", k, rsp_valid, rsp_id, rsp_pxl, exp_q[0].pxl);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (job_ready !== 1'b1 || rd_used !== 4'd7) begin
      n_fail++; $display("FAIL fill_first_pop: ready=%0b used=%0d want 1/7", job_ready, rd_used);
    end
    for (int c = 0; c < 100 && obs_q.size() < 8; c++) @(posedge clk);
    #1;
    n_cmp++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL fill_rsp_count: got %0d want 8", obs_q.size()); end
    got = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL fill_rsp[%0d]: got %h want %h", got, o, e); end
      got++;
    end
    n_cmp++; if (rd_used !== 4'd0) begin n_fail++; $display("FAIL fill_drain_used: got %0d want 0", rd_used); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int   wr0 = n_wr_done, n_wr = 0, n_rd = 0;
    rsp_t o, e;
    for (int i = 0; i < 10; i++) begin
      logic        rd;
      logic [10:0] x;
      logic [9:0]  y;
      rd = 1'($urandom_range(0, 1));
      x  = 11'($urandom_range(0, H_RES - 1));
      y  = 10'($urandom_range(0, 719));
      if (rd) begin
        exp_q.push_back({8'd9, 8'd0, 8'(8'h80 + i), pxl_of(int'(y) * H_RES + int'(x))});
        n_rd++;
      end else n_wr++;
      drive_job(rd, 8'd9, 8'(8'h80 + i), x, y, 24'h123456);
    end
    for (int c = 0; c < 100 && obs_q.size() < n_rd; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (obs_q.size() != n_rd) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want %0d", obs_q.size(), n_rd); end
    n_cmp++; if (n_wr_done - wr0 != n_wr) begin n_fail++; $display("FAIL b2b_wr_count: got %0d want %0d", n_wr_done - wr0, n_wr); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL b2b_rsp: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_oob();
    int rd0 = n_rd_done;
`ifdef GRAPHEME_PXL_GW_BOUNDS_CHK_EN
    drive_job(1'b1, 8'd2, 8'd77, 11'd1280, 10'd0, 24'h0);
    n_cmp++; if (mem_rden !== 1'b0 || mem_wren !== 1'b0) begin n_fail++; $display("FAIL oob_no_access: rden=%0b wren=%0b want 0/0", mem_rden, mem_wren); end
    n_cmp++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_flag: got %0b want 1", oob_err); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (rd_used !== 4'd0 || rsp_valid !== 1'b0 || n_rd_done != rd0) begin
      n_fail++; $display("FAIL oob_no_credit: used=%0d rsp_valid=%0b reads=%0d want 0/0/0", rd_used, rsp_valid, n_rd_done - rd0);
    end
    @(negedge clk);
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    n_cmp++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL oob_clear: got %0b want 0", oob_err); end
`else
    rsp_t o, e;
    exp_q.push_back({8'd2, 8'd0, 8'd77, pxl_of(1280)});
    drive_job(1'b1, 8'd2, 8'd77, 11'd1280, 10'd0, 24'h0);
    n_cmp++; if (mem_rden !== 1'b1 || mem_addr !== 20'd1280) begin n_fail++; $display("FAIL nochk_access: rden=%0b addr=%0d want 1/1280", mem_rden, mem_addr); end
    n_cmp++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL nochk_flag: got %0b want 0", oob_err); end
    for (int c = 0; c < 100 && obs_q.size() < 1; c++) @(posedge clk);
    #1;
    n_cmp++; if (obs_q.size() != 1 || n_rd_done - rd0 != 1) begin
      n_fail++; $display("FAIL nochk_rsp_count: got %0d/%0d want 1/1", obs_q.size(), n_rd_done - rd0);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL nochk_rsp: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
`endif
  endtask

  task automatic test_unsolicited();
    @(negedge clk);
    ret_q.push_back(32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rd_ovrflw !== 1'b1) begin n_fail++; $display("FAIL unsol_flag: got %0b want 1", rd_ovrflw); end
    n_cmp++; if (rsp_valid !== 1'b0 || rd_used !== 4'd0) begin n_fail++; $display("FAIL unsol_no_rsp: valid=%0b used=%0d want 0/0", rsp_valid, rd_used); end
    @(negedge clk);
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    n_cmp++; if (rd_ovrflw !== 1'b0) begin n_fail++; $display("FAIL unsol_clear: got %0b want 0", rd_ovrflw); end
    // drop and clear on the same edge: the set must win
    @(negedge clk);
    ret_q.push_back(32'h01020304);
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    n_cmp++; if (rd_ovrflw !== 1'b1) begin n_fail++; $display("FAIL unsol_set_wins: got %0b want 1", rd_ovrflw); end
    @(negedge clk);
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
  endtask

  task automatic test_reset_mid();
    ret_en = 1'b0;
    for (int i = 0; i < 3; i++) drive_job(1'b1, 8'd4, 8'(i), 11'(i), 10'd10, 24'h0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rd_used !== 4'd3) begin n_fail++; $display("FAIL mid_used: got %0d want 3", rd_used); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %0b want 0", job_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_wren, mem_rden, mem_addr, mem_wdata, rsp_valid, oob_err, rd_ovrflw, rd_used} !== '0) begin
      n_fail++;
      $display("FAIL mid_rst_outputs: wren=%0b rden=%0b addr=%0h wdata=%0h rsp_valid=%0b oob=%0b ovf=%0b used=%0d want all 0",
               mem_wren, mem_rden, mem_addr, mem_wdata, rsp_valid, oob_err, rd_ovrflw, rd_used);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    ret_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (rd_ovrflw !== 1'b1) begin n_fail++; $display("FAIL mid_stale_ovrflw: got %0b want 1", rd_ovrflw); end
    n_cmp++; if (rsp_valid !== 1'b0 || obs_q.size() != 0) begin n_fail++; $display("FAIL mid_stale_rsp: valid=%0b obs=%0d want 0/0", rsp_valid, obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_fill();
    test_back_to_back();
    test_oob();
    test_unsolicited();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
